// File: rtl/mux41_pkg.sv
// Shared types and sizes for the 4:1 mux channel scanner.
package mux41_pkg;

  localparam int unsigned NCH   = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/mux41_next_ch.sv
// Finds the lowest unmasked channel above base (or at base when incl=1).
// last_c is set when no such channel exists.
module mux41_next_ch
  import mux41_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] base,
  input  logic             incl,
  output logic [SEL_W-1:0] nxt_c,
  output logic             last_c
);

  logic found;

  always_comb begin
    nxt_c = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (!found && mask[i] && ((i > int'(base)) || (incl && (i == int'(base))))) begin
        nxt_c = SEL_W'(i);
        found = 1'b1;
      end
    end
    last_c = ~found;
  end

endmodule

// File: rtl/mux41_scan_ctrl.sv
// Scans the unmasked inputs of a 4:1 mux, settling SETTLE_CYC cycles per
// channel, and delivers one 4-bit snapshot per frame on valid/ready.
module mux41_scan_ctrl
  import mux41_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NCH-1:0]   mask,
  input  logic             mux_out,
  output logic [SEL_W-1:0] sel,
  output logic [NCH-1:0]   data,
  output logic             valid,
  input  logic             ready,
  output logic             change,
  output logic             busy
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [NCH-1:0]   shadow_q, shadow_d;
  logic [NCH-1:0]   prev_q, prev_d;
  logic [NCH-1:0]   data_q, data_d;
  logic             valid_q, valid_d;
  logic             change_q, change_d;
  logic             busy_q, busy_d;
  logic             start;

  logic [SEL_W-1:0] nxt_c, first_c;
  logic             last_c, none_c;

  // next channel within the current frame
  mux41_next_ch u_next (
    .mask   (mask_q),
    .base   (sel_q),
    .incl   (1'b0),
    .nxt_c  (nxt_c),
    .last_c (last_c)
  );

  // first channel of a frame about to start; none_c means an empty mask
  mux41_next_ch u_first (
    .mask   (mask),
    .base   (SEL_W'(0)),
    .incl   (1'b1),
    .nxt_c  (first_c),
    .last_c (none_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      shadow_q <= '0;
      prev_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      prev_q   <= prev_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      change_q <= change_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    prev_d   = prev_q;
    data_d   = data_q;
    valid_d  = valid_q;
    change_d = change_q;
    start    = 1'b0;

    unique case (state_q)
      IDLE: start = en;
      SCAN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == SETTLE_LAST) begin
          cnt_d            = '0;
          shadow_d[sel_q]  = mux_out;
          if (!last_c) begin
            sel_d = nxt_c;
          end else begin
            data_d   = shadow_d & mask_q;
            valid_d  = 1'b1;
            change_d = (data_d != prev_q);
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (valid_q && ready) begin
          valid_d = 1'b0;
          prev_d  = data_q;
          state_d = IDLE;
          start   = en;
        end
      end
      default: state_d = IDLE;
    endcase

    // frame start is shared by IDLE and a back-to-back restart from HOLD
    if (start) begin
      mask_d   = mask;
      shadow_d = '0;
      if (none_c) begin
        data_d   = '0;
        valid_d  = 1'b1;
        change_d = (prev_d != '0);
        state_d  = HOLD;
      end else begin
        sel_d   = first_c;
        cnt_d   = '0;
        state_d = SCAN;
      end
    end

    busy_d = (state_d != IDLE);
  end

  assign sel    = sel_q;
  assign data   = data_q;
  assign valid  = valid_q;
  assign change = change_q;
  assign busy   = busy_q;

endmodule
